// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer driving an external 4-bit ripple adder.
// Optional NSA_OVERFLOW_EN adds io_out_overflow (two's-complement signed overflow).
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds valid and data steady until that edge.
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_carryIn,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_carryOut,
`ifdef NSA_OVERFLOW_EN
    output logic             io_out_overflow,
`endif
    output logic [3:0]       io_add_a,
    output logic [3:0]       io_add_b,
    output logic             io_add_carryIn,
    input  logic [3:0]       io_add_sum,
    input  logic             io_add_carryOut
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateE;

    stateE            state;
    stateE            nextState;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             outCarry;
    logic             isLast;

    assign isLast = (idx == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState      = state;
        io_in_ready    = 1'b0;
        io_out_valid   = 1'b0;
        io_add_a       = 4'h0;
        io_add_b       = 4'h0;
        io_add_carryIn = 1'b0;
        case (state)
            IDLE: begin
                io_in_ready = 1'b1;
                if (io_in_valid) nextState = RUN;
            end
            RUN: begin
                io_add_a       = opA[4*idx +: 4];
                io_add_b       = opB[4*idx +: 4];
                io_add_carryIn = carry;
                if (isLast) nextState = DONE;
            end
            DONE: begin
                io_out_valid = 1'b1;
                if (io_out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // The running carry is reloaded at accept; the presented carry only changes during RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            opA      <= '0;
            opB      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            outCarry <= 1'b0;
        end else if (state == IDLE && io_in_valid) begin
            opA   <= io_in_a;
            opB   <= io_in_b;
            carry <= io_in_carryIn;
            idx   <= '0;
        end else if (state == RUN) begin
            result[4*idx +: 4] <= io_add_sum;
            carry              <= io_add_carryOut;
            outCarry           <= io_add_carryOut;
            if (!isLast) idx <= idx + 1'b1;
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic overflow;

    // Top result bit comes straight from the adder on the final nibble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (state == RUN && isLast) begin
            overflow <= (opA[WIDTH-1] == opB[WIDTH-1]) && (io_add_sum[3] != opA[WIDTH-1]);
        end
    end

    assign io_out_overflow = overflow;
`endif

    assign io_out_sum      = result;
    assign io_out_carryOut = outCarry;

endmodule
